execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the pipelined Y86-64 processor.
- Consumes E-register outputs from decode and selects the two ALU operands and the ALU function.
- Drives one instance of the team's 64-bit `alu`: 2-bit control, 00 add / 01 sub / 10 and / 11 xor, signed out plus overflow.
- Owns the condition-code register, evaluates jump/cmov conditions, and holds the E->M pipeline register consumed by the memory stage.

Parameters:
RNONE, 4'hF, register ID meaning "no destination"
STAT_AOK, 3'd1, normal status code (2 HLT, 3 ADR, 4 INS)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
E_stat  input  3  status of instruction in execute
E_icode  input  4  instruction code
E_ifun  input  4  function code
E_valA  input  64  register operand A / forwarded value
E_valB  input  64  register operand B
E_valC  input  64  immediate constant
E_dstE  input  4  ALU-result destination register
E_dstM  input  4  memory-result destination register
m_stat_exc  input  1  exceptional instruction in memory stage
W_stat_exc  input  1  exceptional instruction in writeback stage
M_stall  input  1  hold M register
M_bubble  input  1  load nop bubble into M register
e_valE  output  64  combinational ALU result (forwarding)
e_dstE  output  4  combinational effective dstE (forwarding)
e_Cnd  output  1  combinational condition result
cc_out  output  3  {ZF,SF,OF} current CC register
M_stat  output  3  registered status
M_icode  output  4  registered icode
M_Cnd  output  1  registered condition
M_valE  output  64  registered ALU result
M_valA  output  64  registered valA passthrough
M_dstE  output  4  registered effective dstE
M_dstM  output  4  registered dstM

Behaviour:
- Opcodes used below:
  - 2 cmovXX/rrmovq, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX
  - 8 call, 9 ret, A pushq, B popq, 0 halt, 1 nop
- aluA selection:
  - valA for icode 2, 6
  - valC for icode 3, 4, 5
  - -8 for icode 8, A
  - +8 for icode 9, B
  - 0 otherwise
- aluB selection:
  - valB for icode 4, 5, 6, 8, 9, A, B
  - 0 for icode 2, 3
  - 0 otherwise
- ALU wiring:
  - `alu` port a = aluB, port b = aluA, so valE = aluB OP aluA (subq yields valB - valA).
  - control = E_ifun[1:0] when icode 6, else 2'b00 (add).
  - For icode 6 with ifun > 3, control still uses ifun[1:0]; the instruction is INS-flagged upstream and set_cc covers it.
- set_cc = (E_icode==6) & (E_stat==STAT_AOK) & ~m_stat_exc & ~W_stat_exc.
- On a clk edge with set_cc:
  - ZF = (valE==0)
  - SF = valE[63]
  - OF = alu overflow
  - The new CC is visible to the next instruction in execute (one-cycle latency), not to the one that set it.
- e_Cnd, from the current CC and E_ifun:
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: ~ZF
  - 5 ge: ~(SF^OF)
  - 6 g: ~(SF^OF)&~ZF
  - 7..F: 0
- e_dstE = RNONE when E_icode==2 and ~e_Cnd; otherwise E_dstE.
- M register update priority, per clk edge:
  1. rst: load bubble.
  2. M_bubble: load bubble. Bubble wins over M_stall when both are asserted.
  3. M_stall: hold all M outputs.
  4. Otherwise: load {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.
- Bubble value: stat=STAT_AOK, icode=1, Cnd=0, valE=0, valA=0, dstE=dstM=RNONE.
- CC reset value is {ZF,SF,OF} = 3'b100.
- rst asserted mid-stream discards the in-flight M contents and CC in the same edge.
- M_stall and M_bubble do not affect the CC update; only set_cc does.
- Latency:
  - e_* outputs are combinational from E inputs and CC.
  - M_* outputs appear one clock after the E inputs.
- Signed arithmetic: 64-bit two's complement; wrap-around handled by the ALU; no saturation.

Test Plan:
- Reset: rst=1 for 2 cycles -> cc_out=3'b100; M_icode=1, M_stat=1, M_dstE=M_dstM=F, M_valE=0.
- OPq subq: icode 6, ifun 1, valA=5, valB=3, AOK -> e_valE=-2 (0xFFFF_FFFF_FFFF_FFFE); next cycle cc_out=3'b010, M_valE=-2.
- Overflow add: icode 6, ifun 0, valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE; cc=3'b011; following jl (icode 7, ifun 2) gives e_Cnd=0 and jle gives 0.
- Failed cmov:
  - Setup: CC ZF=0 (after andq of 1 and 3).
  - Stimulus: cmove (icode 2, ifun 3), dstE=4, valA=0x55.
  - Required: e_Cnd=0, e_dstE=F, M_valE=0x55.
- Stack ops:
  - Stimulus: pushq, icode A, valB=0x100 -> M_valE=0xF8, CC unchanged.
  - Stimulus: ret, icode 9, valB=0xF8 -> M_valE=0x100.
- Exception gating and M control:
  - Stimulus: OPq xorq 7^7 with m_stat_exc=1.
  - Required: CC unchanged; M_valE=0.
  - Stimulus: M_stall then M_stall+M_bubble.
  - Required: hold previous M values, then load the bubble.

Source files
------------

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_if
// Description : Bundle of the E-register inputs, the pipeline control lines,
//               the forwarding outputs and the E->M register outputs of the
//               Y86-64 execute stage.
//               master : the driving side (decode / hazard control / memory)
//               slave  : the execute stage itself
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_if;
  // E register contents from decode
  logic [2:0]  E_stat;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic [63:0] E_valC;
  logic [3:0]  E_dstE;
  logic [3:0]  E_dstM;
  // exception and pipeline control
  logic        m_stat_exc;
  logic        W_stat_exc;
  logic        M_stall;
  logic        M_bubble;
  // combinational forwarding outputs
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc_out;
  // M register outputs
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output m_stat_exc, W_stat_exc, M_stall, M_bubble,
    input  e_valE, e_dstE, e_Cnd, cc_out,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  m_stat_exc, W_stat_exc, M_stall, M_bubble,
    output e_valE, e_dstE, e_Cnd, cc_out,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 64-bit two's complement ALU.
//               control 00 add (a+b), 01 sub (a-b), 10 and, 11 xor.
//               overflow is meaningful only for add/sub; logic ops clear it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
  input  logic [63:0]        a,
  input  logic [63:0]        b,
  input  logic [1:0]         control,
  output logic signed [63:0] out,
  output logic               overflow
);

  // Operation select with signed-overflow detection on add/sub
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (control)
      2'b00: begin
        out      = a + b;
        overflow = (a[63] == b[63]) && (out[63] != a[63]);
      end
      2'b01: begin
        out      = a - b;
        overflow = (a[63] != b[63]) && (out[63] != a[63]);
      end
      2'b10: out = a & b;
      default: out = a ^ b;
    endcase
  end

endmodule

// ============================================================================
// Module      : execute_stage
// Description : Execute stage of the pipelined Y86-64 processor. Selects ALU
//               operands, owns the condition-code register, evaluates
//               jump/cmov conditions and holds the E->M pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [2:0] STAT_AOK = 3'd1
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  // Instruction codes
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Condition codes {ZF,SF,OF}; the reset value reads as "last result zero"
  localparam logic [2:0] CC_RESET = 3'b100;

  // Stack pointer adjustment constants
  localparam logic [63:0] C_MINUS8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] C_PLUS8  = 64'h0000_0000_0000_0008;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]  cc_q,      cc_d;
  logic [2:0]  m_stat_q,  m_stat_d;
  logic [3:0]  m_icode_q, m_icode_d;
  logic        m_cnd_q,   m_cnd_d;
  logic [63:0] m_vale_q,  m_vale_d;
  logic [63:0] m_vala_q,  m_vala_d;
  logic [3:0]  m_dste_q,  m_dste_d;
  logic [3:0]  m_dstm_q,  m_dstm_d;

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic [63:0]        alu_a;     // aluA: the "second" operand (valA/valC/+-8)
  logic [63:0]        alu_b;     // aluB: the "first" operand (valB or 0)
  logic [1:0]         alu_fun;
  logic signed [63:0] alu_out;
  logic               alu_ovf;
  logic               set_cc;
  logic               cnd;
  logic [3:0]         dste_eff;
  logic               zf, sf, of_flag;

  assign zf      = cc_q[2];
  assign sf      = cc_q[1];
  assign of_flag = cc_q[0];

  // aluA selection: register operand, immediate, or stack adjustment
  always_comb begin
    alu_a = '0;
    case (bus.E_icode)
      I_RRMOVQ, I_OPQ:            alu_a = bus.E_valA;
      I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ:                   alu_a = bus.E_valC;
      I_CALL, I_PUSHQ:            alu_a = C_MINUS8;
      I_RET, I_POPQ:              alu_a = C_PLUS8;
      default:                    alu_a = '0;
    endcase
  end

  // aluB selection: valB for memory/stack/arith ops, zero for moves
  always_comb begin
    alu_b = '0;
    case (bus.E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ,
      I_CALL, I_RET, I_PUSHQ,
      I_POPQ:                     alu_b = bus.E_valB;
      default:                    alu_b = '0;
    endcase
  end

  // ALU function: only OPq uses ifun; everything else is an address/move add.
  // Undefined OPq functions (ifun > 3) still use ifun[1:0]; upstream marks
  // them INS so set_cc suppresses any CC effect.
  always_comb begin
    alu_fun = 2'b00;
    if (bus.E_icode == I_OPQ) begin
      alu_fun = bus.E_ifun[1:0];
    end
  end

  // Port a = aluB, port b = aluA so subq computes valB - valA
  alu u_alu (
    .a        (alu_b),
    .b        (alu_a),
    .control  (alu_fun),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  // CC writes only for a healthy OPq with no exception further down the pipe
  always_comb begin
    set_cc = (bus.E_icode == I_OPQ) && (bus.E_stat == STAT_AOK) &&
             !bus.m_stat_exc && !bus.W_stat_exc;
  end

  // Jump / conditional-move evaluation from the current (registered) CC
  always_comb begin
    cnd = 1'b0;
    case (bus.E_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (sf ^ of_flag) | zf;
      4'h2:    cnd = sf ^ of_flag;
      4'h3:    cnd = zf;
      4'h4:    cnd = ~zf;
      4'h5:    cnd = ~(sf ^ of_flag);
      4'h6:    cnd = ~(sf ^ of_flag) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes nowhere
  always_comb begin
    dste_eff = bus.E_dstE;
    if ((bus.E_icode == I_RRMOVQ) && !cnd) begin
      dste_eff = RNONE;
    end
  end

  // Next CC: new flags from this ALU result, else hold. Independent of
  // M_stall / M_bubble.
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d = {(alu_out == 64'sd0), alu_out[63], alu_ovf};
    end
  end

  // Next M register: bubble beats stall, stall holds, otherwise load from E
  always_comb begin
    m_stat_d  = bus.E_stat;
    m_icode_d = bus.E_icode;
    m_cnd_d   = cnd;
    m_vale_d  = alu_out;
    m_vala_d  = bus.E_valA;
    m_dste_d  = dste_eff;
    m_dstm_d  = bus.E_dstM;
    if (bus.M_bubble) begin
      m_stat_d  = STAT_AOK;
      m_icode_d = I_NOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
      m_dstm_d  = RNONE;
    end else if (bus.M_stall) begin
      m_stat_d  = m_stat_q;
      m_icode_d = m_icode_q;
      m_cnd_d   = m_cnd_q;
      m_vale_d  = m_vale_q;
      m_vala_d  = m_vala_q;
      m_dste_d  = m_dste_q;
      m_dstm_d  = m_dstm_q;
    end
  end

  // State update; reset discards both CC and in-flight M contents
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q      <= CC_RESET;
      m_stat_q  <= STAT_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  // Output mapping
  assign bus.e_valE  = alu_out;
  assign bus.e_dstE  = dste_eff;
  assign bus.e_Cnd   = cnd;
  assign bus.cc_out  = cc_q;
  assign bus.M_stat  = m_stat_q;
  assign bus.M_icode = m_icode_q;
  assign bus.M_Cnd   = m_cnd_q;
  assign bus.M_valE  = m_vale_q;
  assign bus.M_valA  = m_vala_q;
  assign bus.M_dstE  = m_dste_q;
  assign bus.M_dstM  = m_dstm_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Directed table-driven bench for execute_stage, plus short
//               hand-written sequences for stall, bubble and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        m_exc;
    logic        w_exc;
    logic [63:0] x_valE;
    logic [3:0]  x_dstE;
    logic        x_cnd;
    logic [2:0]  x_cc;   // CC expected after the edge
  } vec_t;

  function automatic vec_t mk(
    input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
    input logic [63:0] valA, input logic [63:0] valB, input logic [63:0] valC,
    input logic [3:0] dstE, input logic [3:0] dstM,
    input logic m_exc, input logic w_exc,
    input logic [63:0] x_valE, input logic [3:0] x_dstE,
    input logic x_cnd, input logic [2:0] x_cc);
    vec_t v;
    v.stat = stat; v.icode = icode; v.ifun = ifun;
    v.valA = valA; v.valB = valB; v.valC = valC;
    v.dstE = dstE; v.dstM = dstM; v.m_exc = m_exc; v.w_exc = w_exc;
    v.x_valE = x_valE; v.x_dstE = x_dstE; v.x_cnd = x_cnd; v.x_cc = x_cc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.E_stat     = v.stat;
    bus.E_icode    = v.icode;
    bus.E_ifun     = v.ifun;
    bus.E_valA     = v.valA;
    bus.E_valB     = v.valB;
    bus.E_valC     = v.valC;
    bus.E_dstE     = v.dstE;
    bus.E_dstM     = v.dstM;
    bus.m_stat_exc = v.m_exc;
    bus.W_stat_exc = v.w_exc;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, " M_stat"},  64'(bus.M_stat),  64'd1);
    check({tag, " M_icode"}, 64'(bus.M_icode), 64'h1);
    check({tag, " M_Cnd"},   64'(bus.M_Cnd),   64'd0);
    check({tag, " M_valE"},  bus.M_valE,       64'd0);
    check({tag, " M_valA"},  bus.M_valA,       64'd0);
    check({tag, " M_dstE"},  64'(bus.M_dstE),  64'hF);
    check({tag, " M_dstM"},  64'(bus.M_dstM),  64'hF);
  endtask

  localparam logic [63:0] MAXP  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG2  = 64'hFFFF_FFFF_FFFF_FFFE;

  vec_t vt[21];
  vec_t v;

  initial begin
    n_cmp = 0;
    n_err = 0;

    //           stat  ic    ifn   valA    valB    valC      dstE  dstM  m  w  x_valE     xdE   xc  x_cc
    vt[0]  = mk(3'd1, 4'h6, 4'h1, 64'd5,  64'd3,  64'd0,    4'h3, 4'hF, 0, 0, NEG2,      4'h3, 1, 3'b010); // subq, le vs reset CC
    vt[1]  = mk(3'd1, 4'h6, 4'h0, MAXP,   MAXP,   64'd0,    4'h3, 4'hF, 0, 0, NEG2,      4'h3, 1, 3'b011); // addq overflow
    vt[2]  = mk(3'd1, 4'h7, 4'h2, 64'd0,  64'd0,  64'h40,   4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 0, 3'b011); // jl
    vt[3]  = mk(3'd1, 4'h7, 4'h1, 64'd0,  64'd0,  64'h40,   4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 0, 3'b011); // jle
    vt[4]  = mk(3'd1, 4'h7, 4'h5, 64'd0,  64'd0,  64'h40,   4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 1, 3'b011); // jge
    vt[5]  = mk(3'd1, 4'h6, 4'h2, 64'd1,  64'd3,  64'd0,    4'h2, 4'hF, 0, 0, 64'd1,     4'h2, 0, 3'b000); // andq
    vt[6]  = mk(3'd1, 4'h2, 4'h3, 64'h55, 64'd0,  64'd0,    4'h4, 4'hF, 0, 0, 64'h55,    4'hF, 0, 3'b000); // cmove fails
    vt[7]  = mk(3'd1, 4'h2, 4'h4, 64'h66, 64'd0,  64'd0,    4'h5, 4'hF, 0, 0, 64'h66,    4'h5, 1, 3'b000); // cmovne taken
    vt[8]  = mk(3'd1, 4'hA, 4'h0, 64'h77, 64'h100,64'd0,    4'h4, 4'hF, 0, 0, 64'hF8,    4'h4, 1, 3'b000); // pushq
    vt[9]  = mk(3'd1, 4'h9, 4'h0, 64'h77, 64'hF8, 64'd0,    4'h4, 4'hF, 0, 0, 64'h100,   4'h4, 1, 3'b000); // ret
    vt[10] = mk(3'd1, 4'h3, 4'h0, 64'd0,  64'd0,  64'h1234, 4'h6, 4'hF, 0, 0, 64'h1234,  4'h6, 1, 3'b000); // irmovq
    vt[11] = mk(3'd1, 4'h5, 4'h0, 64'd0,  64'h20, 64'h10,   4'hF, 4'h7, 0, 0, 64'h30,    4'hF, 1, 3'b000); // mrmovq
    vt[12] = mk(3'd1, 4'h6, 4'h3, 64'd7,  64'd7,  64'd0,    4'h2, 4'hF, 1, 0, 64'd0,     4'h2, 0, 3'b000); // xorq, m exc
    vt[13] = mk(3'd1, 4'h6, 4'h3, 64'd7,  64'd7,  64'd0,    4'h2, 4'hF, 0, 1, 64'd0,     4'h2, 0, 3'b000); // xorq, W exc
    vt[14] = mk(3'd3, 4'h6, 4'h3, 64'd7,  64'd7,  64'd0,    4'h2, 4'hF, 0, 0, 64'd0,     4'h2, 0, 3'b000); // xorq, ADR
    vt[15] = mk(3'd1, 4'h6, 4'h3, 64'd7,  64'd7,  64'd0,    4'h2, 4'hF, 0, 0, 64'd0,     4'h2, 0, 3'b100); // xorq sets ZF
    vt[16] = mk(3'd1, 4'h7, 4'h3, 64'd0,  64'd0,  64'd0,    4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 1, 3'b100); // je
    vt[17] = mk(3'd1, 4'h6, 4'h1, 64'd1,  MINN,   64'd0,    4'h3, 4'hF, 0, 0, MAXP,      4'h3, 1, 3'b001); // sub underflow
    vt[18] = mk(3'd1, 4'h7, 4'h2, 64'd0,  64'd0,  64'd0,    4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 1, 3'b001); // jl
    vt[19] = mk(3'd1, 4'h7, 4'h7, 64'd0,  64'd0,  64'd0,    4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 0, 3'b001); // ifun 7
    vt[20] = mk(3'd1, 4'h7, 4'h6, 64'd0,  64'd0,  64'd0,    4'hF, 4'hF, 0, 0, 64'd0,     4'hF, 0, 3'b001); // jg

    // Reset for two cycles
    rst = 1'b1;
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;
    drive(mk(3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 4'hF, 0, 3'b100));
    repeat (2) @(posedge clk);
    #1;
    check("reset cc_out", 64'(bus.cc_out), 64'b100);
    check_bubble("reset");

    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 21; i++) begin
      drive(vt[i]);
      #1;
      check($sformatf("v%0d e_valE", i), bus.e_valE,        vt[i].x_valE);
      check($sformatf("v%0d e_dstE", i), 64'(bus.e_dstE),   64'(vt[i].x_dstE));
      check($sformatf("v%0d e_Cnd", i),  64'(bus.e_Cnd),    64'(vt[i].x_cnd));
      @(posedge clk);
      #1;
      check($sformatf("v%0d cc_out", i),  64'(bus.cc_out),  64'(vt[i].x_cc));
      check($sformatf("v%0d M_valE", i),  bus.M_valE,       vt[i].x_valE);
      check($sformatf("v%0d M_dstE", i),  64'(bus.M_dstE),  64'(vt[i].x_dstE));
      check($sformatf("v%0d M_Cnd", i),   64'(bus.M_Cnd),   64'(vt[i].x_cnd));
      check($sformatf("v%0d M_icode", i), 64'(bus.M_icode), 64'(vt[i].icode));
      check($sformatf("v%0d M_stat", i),  64'(bus.M_stat),  64'(vt[i].stat));
      check($sformatf("v%0d M_valA", i),  bus.M_valA,       vt[i].valA);
      check($sformatf("v%0d M_dstM", i),  64'(bus.M_dstM),  64'(vt[i].dstM));
      @(negedge clk);
    end

    // Load a known M value: irmovq 0xABC -> r6
    drive(mk(3'd1, 4'h3, 4'h0, 0, 0, 64'hABC, 4'h6, 4'hF, 0, 0, 0, 4'hF, 0, 3'b001));
    @(posedge clk);
    #1;
    check("load M_valE", bus.M_valE, 64'hABC);

    // Stall: M holds while a subq 1-1 still updates CC to ZF
    @(negedge clk);
    bus.M_stall = 1'b1;
    drive(mk(3'd1, 4'h6, 4'h1, 64'd1, 64'd1, 0, 4'h3, 4'hF, 0, 0, 0, 4'hF, 0, 3'b001));
    #1;
    check("stall e_valE", bus.e_valE, 64'd0);
    @(posedge clk);
    #1;
    check("stall M_valE",  bus.M_valE,       64'hABC);
    check("stall M_icode", 64'(bus.M_icode), 64'h3);
    check("stall M_dstE",  64'(bus.M_dstE),  64'h6);
    check("stall cc_out",  64'(bus.cc_out),  64'b100);

    // Stall + bubble: bubble wins
    @(negedge clk);
    bus.M_bubble = 1'b1;
    @(posedge clk);
    #1;
    check_bubble("stall+bubble");

    // andq 1&3 clears ZF and loads M normally
    @(negedge clk);
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;
    drive(mk(3'd1, 4'h6, 4'h2, 64'd1, 64'd3, 0, 4'h2, 4'hF, 0, 0, 0, 4'hF, 0, 3'b000));
    @(posedge clk);
    #1;
    check("andq cc_out", 64'(bus.cc_out), 64'b000);
    check("andq M_valE", bus.M_valE,      64'd1);

    // Mid-run reset with an OPq in execute: CC and M both discarded
    @(negedge clk);
    rst = 1'b1;
    drive(mk(3'd1, 4'h6, 4'h0, 64'd2, 64'd3, 0, 4'h2, 4'hF, 0, 0, 0, 4'hF, 0, 3'b000));
    @(posedge clk);
    #1;
    check("midrst cc_out", 64'(bus.cc_out), 64'b100);
    check_bubble("midrst");

    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
